// File: rtl/sync_fifo_prog_if.sv
// sync_fifo_prog_if: write/read handshake, data and status bundle for sync_fifo_prog.
interface sync_fifo_prog_if #(
    parameter int F_WIDTH = 32,
    parameter int F_DEPTH = 16
);
    localparam int C_W = $clog2(F_DEPTH + 1);
    logic               wr_en;
    logic [F_WIDTH-1:0] data_in;
    logic               rd_en;
    logic [F_WIDTH-1:0] rd_data;
    logic               rd_valid;
    logic               full;
    logic               empty;
    logic               almost_full;
    logic               almost_empty;
    logic [C_W-1:0]     count;
    logic               wr_err;
    logic               rd_err;
    modport master (
        output wr_en, data_in, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count, wr_err, rd_err
    );
    modport slave (
        input  wr_en, data_in, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, wr_err, rd_err
    );
endinterface

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: parametrised single-clock FIFO with programmable flags and standard/FWFT read.
module sync_fifo_prog #(
    parameter int F_WIDTH  = 32,
    parameter int F_DEPTH  = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input logic             clk,
    input logic             reset,
    sync_fifo_prog_if.slave f
);
    localparam int C_W = $clog2(F_DEPTH + 1);
    localparam int P_W = $clog2(F_DEPTH);
    localparam logic [C_W-1:0] DEPTH_C = C_W'(F_DEPTH);
    localparam logic [C_W-1:0] AF_C    = C_W'(AF_LEVEL);
    localparam logic [C_W-1:0] AE_C    = C_W'(AE_LEVEL);
    localparam logic [P_W-1:0] LAST_P  = P_W'(F_DEPTH - 1);
    logic [F_WIDTH-1:0] mem [F_DEPTH];
    logic [P_W-1:0]     wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [C_W-1:0]     cnt, cnt_n;
    logic [F_WIDTH-1:0] rd_q;
    logic               rd_v_q, full_q, empty_q, af_q, ae_q, wr_err_q, rd_err_q;
    logic               rd_acc, wr_acc;
    // A full FIFO may still take a write when a read frees a slot on the same edge.
    always_comb begin
        rd_acc   = f.rd_en & ~empty_q;
        wr_acc   = f.wr_en & (~full_q | rd_acc);
        wr_ptr_n = (wr_ptr == LAST_P) ? '0 : wr_ptr + P_W'(1);
        rd_ptr_n = (rd_ptr == LAST_P) ? '0 : rd_ptr + P_W'(1);
        cnt_n    = cnt + C_W'(wr_acc) - C_W'(rd_acc);
    end
    always_ff @(posedge clk)
        if (reset && wr_acc)
            mem[wr_ptr] <= f.data_in;
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            rd_q     <= '0;
            rd_v_q   <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_ptr   <= wr_acc ? wr_ptr_n : wr_ptr;
            rd_ptr   <= rd_acc ? rd_ptr_n : rd_ptr;
            rd_q     <= rd_acc ? mem[rd_ptr] : rd_q;
            rd_v_q   <= rd_acc;
            cnt      <= cnt_n;
            full_q   <= cnt_n == DEPTH_C;
            empty_q  <= cnt_n == '0;
            af_q     <= cnt_n >= AF_C;
            ae_q     <= cnt_n <= AE_C;
            wr_err_q <= f.wr_en & ~wr_acc;
            rd_err_q <= f.rd_en & ~rd_acc;
        end
    end
    assign f.rd_data      = (FWFT != 0) ? (empty_q ? '0 : mem[rd_ptr]) : rd_q;
    assign f.rd_valid     = (FWFT != 0) ? ~empty_q : rd_v_q;
    assign f.full         = full_q;
    assign f.empty        = empty_q;
    assign f.almost_full  = af_q;
    assign f.almost_empty = ae_q;
    assign f.count        = cnt;
    assign f.wr_err       = wr_err_q;
    assign f.rd_err       = rd_err_q;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog: scoreboard bench for a standard-read 16-deep FIFO and an FWFT 5-deep FIFO.
module tb_sync_fifo_prog;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    sync_fifo_prog_if #(.F_WIDTH(32), .F_DEPTH(16)) ia ();
    sync_fifo_prog_if #(.F_WIDTH(32), .F_DEPTH(5))  ib ();
    sync_fifo_prog #(.F_WIDTH(32), .F_DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) dut_a (
        .clk(clk), .reset(reset), .f(ia.slave)
    );
    sync_fifo_prog #(.F_WIDTH(32), .F_DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1)) dut_b (
        .clk(clk), .reset(reset), .f(ib.slave)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // Standard-read words are scored against the queue whenever rd_valid shows up.
    task automatic step();
        @(posedge clk);
        #1;
        if (ia.rd_valid) begin
            if (qa.size() == 0) check("a_sb_extra", 64'(qa.size()), 64'(1));
            else check("a_sb_data", 64'(ia.rd_data), 64'(qa.pop_front()));
        end
    endtask
    task automatic drive_a(input logic w, input logic r, input logic [31:0] d);
        ia.wr_en = w;
        ia.rd_en = r;
        ia.data_in = d;
    endtask
    task automatic drive_b(input logic w, input logic r, input logic [31:0] d);
        ib.wr_en = w;
        ib.rd_en = r;
        ib.data_in = d;
    endtask
    initial begin
        drive_a(1'b0, 1'b0, 32'h0);
        drive_b(1'b0, 1'b0, 32'h0);
        step();
        step();
        check("rst_count", 64'(ia.count), 64'(0));
        check("rst_empty", 64'(ia.empty), 64'(1));
        check("rst_full", 64'(ia.full), 64'(0));
        check("rst_af", 64'(ia.almost_full), 64'(0));
        check("rst_ae", 64'(ia.almost_empty), 64'(1));
        check("rst_valid", 64'(ia.rd_valid), 64'(0));
        check("rst_data", 64'(ia.rd_data), 64'(0));
        check("rst_errs", 64'({ia.wr_err, ia.rd_err}), 64'(0));
        check("rst_b_empty", 64'(ib.empty), 64'(1));
        reset = 1'b1;
        // T1 fill
        for (int i = 1; i <= 16; i++) begin
            drive_a(1'b1, 1'b0, 32'(i));
            qa.push_back(32'(i));
            step();
            check("t1_count", 64'(ia.count), 64'(i));
            check("t1_full", 64'(ia.full), 64'(i == 16));
            check("t1_af", 64'(ia.almost_full), 64'(i >= 14));
            check("t1_ae", 64'(ia.almost_empty), 64'(i <= 2));
        end
        drive_a(1'b1, 1'b0, 32'h11);
        step();
        check("t1_wr_err", 64'(ia.wr_err), 64'(1));
        check("t1_ovf_count", 64'(ia.count), 64'(16));
        drive_a(1'b0, 1'b0, 32'h0);
        step();
        check("t1_wr_err_pulse", 64'(ia.wr_err), 64'(0));
        // T2 drain
        for (int j = 1; j <= 16; j++) begin
            drive_a(1'b0, 1'b1, 32'h0);
            step();
            check("t2_valid", 64'(ia.rd_valid), 64'(1));
            check("t2_count", 64'(ia.count), 64'(16 - j));
            check("t2_ae", 64'(ia.almost_empty), 64'(16 - j <= 2));
            check("t2_empty", 64'(ia.empty), 64'(j == 16));
        end
        drive_a(1'b0, 1'b0, 32'h0);
        step();
        check("t2_valid_drop", 64'(ia.rd_valid), 64'(0));
        drive_a(1'b0, 1'b1, 32'h0);
        step();
        check("t2_rd_err", 64'(ia.rd_err), 64'(1));
        check("t2_hold", 64'(ia.rd_data), 64'h10);
        check("t2_unf_valid", 64'(ia.rd_valid), 64'(0));
        // T3 simultaneous at full
        for (int i = 1; i <= 16; i++) begin
            drive_a(1'b1, 1'b0, 32'(32'h100 + i));
            qa.push_back(32'(32'h100 + i));
            step();
        end
        drive_a(1'b1, 1'b1, 32'hAA);
        qa.push_back(32'hAA);
        step();
        check("t3_no_wr_err", 64'(ia.wr_err), 64'(0));
        check("t3_count", 64'(ia.count), 64'(16));
        check("t3_full", 64'(ia.full), 64'(1));
        for (int j = 0; j < 16; j++) begin
            drive_a(1'b0, 1'b1, 32'h0);
            step();
        end
        check("t3_last", 64'(ia.rd_data), 64'hAA);
        check("t3_drained", 64'(qa.size()), 64'(0));
        check("t3_empty", 64'(ia.empty), 64'(1));
        // T4 simultaneous at empty
        drive_a(1'b1, 1'b1, 32'h55);
        qa.push_back(32'h55);
        step();
        check("t4_rd_err", 64'(ia.rd_err), 64'(1));
        check("t4_count", 64'(ia.count), 64'(1));
        check("t4_valid", 64'(ia.rd_valid), 64'(0));
        drive_a(1'b0, 1'b1, 32'h0);
        step();
        check("t4_read", 64'(qa.size()), 64'(0));
        // T6 reset mid-stream
        for (int i = 0; i < 7; i++) begin
            drive_a(1'b1, 1'b0, 32'(32'h200 + i));
            step();
        end
        check("t6_count7", 64'(ia.count), 64'(7));
        drive_a(1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("t6_empty", 64'(ia.empty), 64'(1));
        check("t6_count", 64'(ia.count), 64'(0));
        check("t6_valid", 64'(ia.rd_valid), 64'(0));
        drive_a(1'b1, 1'b0, 32'h77);
        qa.push_back(32'h77);
        step();
        drive_a(1'b0, 1'b1, 32'h0);
        step();
        check("t6_read", 64'(qa.size()), 64'(0));
        drive_a(1'b0, 1'b0, 32'h0);
        // T5 FWFT with wrap on a 5-deep FIFO
        for (int k = 0; k < 12; k++) begin
            drive_b(1'b1, k >= 3, 32'(k));
            if (k >= 3) begin
                check("t5_valid", 64'(ib.rd_valid), 64'(1));
                check("t5_head", 64'(ib.rd_data), 64'(qb.pop_front()));
            end
            qb.push_back(32'(k));
            step();
            if (k == 0) check("t5_first_vis", 64'(ib.rd_data), 64'(0));
        end
        check("t5_count", 64'(ib.count), 64'(3));
        while (qb.size() > 0) begin
            check("t5_drain_valid", 64'(ib.rd_valid), 64'(1));
            check("t5_drain_head", 64'(ib.rd_data), 64'(qb.pop_front()));
            drive_b(1'b0, 1'b1, 32'h0);
            step();
        end
        drive_b(1'b0, 1'b0, 32'h0);
        check("t5_empty", 64'(ib.empty), 64'(1));
        check("t5_valid_low", 64'(ib.rd_valid), 64'(0));
        for (int i = 0; i < 5; i++) begin
            drive_b(1'b1, 1'b0, 32'(32'h5A + i));
            qb.push_back(32'(32'h5A + i));
            step();
            check("t5_head_stable", 64'(ib.rd_data), 64'h5A);
            check("t5_af", 64'(ib.almost_full), 64'(i + 1 >= 4));
            check("t5_full", 64'(ib.full), 64'(i == 4));
        end
        drive_b(1'b1, 1'b0, 32'hEE);
        step();
        check("t5_wr_err", 64'(ib.wr_err), 64'(1));
        check("t5_ovf_count", 64'(ib.count), 64'(5));
        while (qb.size() > 0) begin
            check("t5_fill_head", 64'(ib.rd_data), 64'(qb.pop_front()));
            drive_b(1'b0, 1'b1, 32'h0);
            step();
        end
        drive_b(1'b0, 1'b0, 32'h0);
        check("t5_final_empty", 64'(ib.empty), 64'(1));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
